mult_div_ctrl: RTL and testbench
================================

MULT_DIV_CTRL -- requirements
Module: mult_div_ctrl

Interface
REQ-001 clk  input  1  system clock; all state updates on rising edge.
REQ-002 rst  input  1  reset, asynchronous, active-high.
REQ-003 start  input  1  operation request; sampled only in IDLE.
REQ-004 op  input  2  operation: 2'b00 MULT, 2'b01 DIV, 2'b10 MULTU, 2'b11 DIVU.
REQ-005 a  input  32  operand A (multiplicand or dividend); sampled on the accepting edge.
REQ-006 b  input  32  operand B (multiplier or divisor); sampled on the accepting edge.
REQ-007 busy  output  1  high while an accepted operation is in progress, including the DONE cycle.
REQ-008 done  output  1  one-cycle pulse: HI/LO results valid.
REQ-009 divZero  output  1  one-cycle pulse with done when DIV/DIVU had b==0.
REQ-010 hi  output  32  HI register: product upper word or remainder.
REQ-011 lo  output  32  LO register: product lower word or quotient.

Function
REQ-012 The FSM SHALL have states IDLE, MULT, DIV, FIX and DONE.
REQ-013 In IDLE with start=1, the edge SHALL latch a, b and op, clear the 5-bit iteration counter, and move to MULT (op[0]=0) or DIV (op[0]=1).
REQ-014 In IDLE, DIV/DIVU with b==0 SHALL go directly to DONE with divZero=1; hi/lo SHALL be unchanged.
REQ-015 MULT SHALL run exactly 32 iterations (counter 0..31), one per cycle, then go to DONE; hi:lo SHALL be loaded with the 64-bit product on the edge entering DONE.
REQ-016 DIV SHALL run exactly 32 restoring iterations on operand magnitudes, then go to FIX.
REQ-017 FIX SHALL apply signs for one cycle and then go to DONE: quotient sign = sign(a) XOR sign(b); remainder sign = sign(a). lo SHALL be the quotient and hi the remainder.
REQ-018 DONE SHALL assert done for exactly one cycle and then return to IDLE.
REQ-019 Latency from the accepting edge to done high SHALL be: 33 cycles for MULT, 34 for DIV, 1 for divide-by-zero.
REQ-020 start SHALL be ignored in every state other than IDLE; requests are not queued.
REQ-021 Signed DIV of 0x80000000 by 0xFFFFFFFF SHALL give lo=0x80000000 and hi=0 (wraps, no exception).
REQ-022 hi and lo SHALL hold their values between operations; only the DONE entry or reset modifies them.

Reset
REQ-023 rst=1 SHALL immediately force IDLE, with busy=0, done=0, divZero=0, hi=0, lo=0, and counter and latched operands cleared.
REQ-024 Reset during MULT, DIV or FIX SHALL abort the operation with no partial result visible.
REQ-025 The first start SHALL be accepted on the first rising edge after rst deasserts.

Configuration
REQ-026 With MULT_DIV_UNSIGNED_EN defined, op[1]=1 SHALL select unsigned operation: MULTU/DIVU, zero-extended operands and no FIX sign correction (FIX still takes one cycle, so latency is unchanged).
REQ-027 Without MULT_DIV_UNSIGNED_EN, op[1] SHALL be ignored and every operation treated as signed.

Structure
REQ-028 The shared CPU package SHALL hold the op encodings, the FSM state encodings, the data width (32) and the iteration count (32).
REQ-029 One sub-module, div_restore_step, SHALL implement one combinational restoring-division step (shift, trial subtract, select) and be instantiated once.

Verification
REQ-030 MULT a=7, b=0xFFFFFFFD -> done at cycle 33, hi=0xFFFFFFFF, lo=0xFFFFFFEB.
REQ-031 DIV a=100, b=7 -> done at cycle 34, lo=14, hi=2; DIV a=0xFFFFFFF9, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-032 DIV a=5, b=0 with prior hi=0x11, lo=0x22 -> done and divZero at cycle 1, hi=0x11, lo=0x22.
REQ-033 start pulsed at cycle 5 of a MULT -> ignored, single done at cycle 33; rst at cycle 10 of a DIV -> busy=0, hi=lo=0, no done.
REQ-034 DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-035 With the macro, MULTU 0xFFFFFFFF*2 -> hi=1, lo=0xFFFFFFFE; without it, the same op -> hi=0xFFFFFFFF, lo=0xFFFFFFFE.

Source files
------------

// File: rtl/mult_div_ctrl_pkg.sv
// Shared definitions for the iterative multiply/divide controller:
// op and FSM state encodings, data width and iteration count.
package mult_div_ctrl_pkg;

  localparam int DATA_W = 32;
  localparam int ITERS  = 32;
  localparam int CNT_W  = 5;

  // op[0] selects divide, op[1] selects the unsigned variant
  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_DIV   = 2'b01,
    OP_MULTU = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    MULT = 3'd1,
    DIV  = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } state_e;

  function automatic logic op_is_div(input logic [1:0] op);
    return op[0];
  endfunction

endpackage

// File: rtl/mult_div_ctrl_if.sv
// Request/result bundle between a CPU core and mult_div_ctrl.
interface mult_div_ctrl_if;
  import mult_div_ctrl_pkg::*;

  logic              start;
  logic [1:0]        op;
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic              busy;
  logic              done;
  logic              divZero;
  logic [DATA_W-1:0] hi;
  logic [DATA_W-1:0] lo;

  modport master (output start, op, a, b, input busy, done, divZero, hi, lo);
  modport slave  (input start, op, a, b, output busy, done, divZero, hi, lo);

endinterface

// File: rtl/mult_div_ctrl_div_restore_step.sv
// One combinational restoring-division step: shift the next dividend bit into
// the partial remainder, trial-subtract the divisor, keep or restore.
module div_restore_step
  import mult_div_ctrl_pkg::*;
(
  input  logic [DATA_W-1:0] rem,
  input  logic [DATA_W-1:0] quo,
  input  logic [DATA_W-1:0] dvs,
  output logic [DATA_W-1:0] rem_next,
  output logic [DATA_W-1:0] quo_next
);

  logic [DATA_W+1:0] shifted;
  logic [DATA_W+1:0] diff;

  always_comb begin
    shifted  = {1'b0, rem, quo[DATA_W-1]};
    diff     = shifted - {2'b00, dvs};
    // borrow out of the widened difference means the trial subtract failed
    if (diff[DATA_W+1]) begin
      rem_next = shifted[DATA_W-1:0];
      quo_next = {quo[DATA_W-2:0], 1'b0};
    end else begin
      rem_next = diff[DATA_W-1:0];
      quo_next = {quo[DATA_W-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/mult_div_ctrl.sv
// Iterative 32x32 multiply / restoring divide unit with HI/LO result registers.
// Optional MULT_DIV_UNSIGNED_EN enables op[1] as the unsigned (MULTU/DIVU) select.
module mult_div_ctrl
  import mult_div_ctrl_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  mult_div_ctrl_if.slave bus
);

`ifdef MULT_DIV_UNSIGNED_EN
  localparam logic UNS_EN = 1'b1;
`else
  localparam logic UNS_EN = 1'b0;
`endif

  state_e                state, nxt;
  logic [CNT_W-1:0]      cnt;
  logic                  uns_r, a_neg, b_neg, dz_r;
  logic [2*DATA_W-1:0]   mcand, acc, acc_next;
  logic [DATA_W-1:0]     mplier;
  logic [DATA_W-1:0]     rem, quo, dvs, rem_step, quo_step;
  logic [DATA_W-1:0]     hi_r, lo_r;
  logic                  uns_in, last;

  function automatic logic [DATA_W-1:0] cond_neg(input logic [DATA_W-1:0] v,
                                                 input logic neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

  assign uns_in = UNS_EN & bus.op[1];
  assign last   = (cnt == CNT_W'(ITERS - 1));

  div_restore_step u_step (
    .rem      (rem),
    .quo      (quo),
    .dvs      (dvs),
    .rem_next (rem_step),
    .quo_next (quo_step)
  );

  // Multiplier bit 31 carries negative weight for signed operands
  always_comb begin
    acc_next = acc;
    if (mplier[0]) begin
      if (last && !uns_r) acc_next = acc - mcand;
      else                acc_next = acc + mcand;
    end
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE: if (bus.start) begin
        if (op_is_div(bus.op)) nxt = (bus.b == '0) ? DONE : DIV;
        else                   nxt = MULT;
      end
      MULT:    if (last) nxt = DONE;
      DIV:     if (last) nxt = FIX;
      FIX:     nxt = DONE;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      uns_r  <= 1'b0;
      a_neg  <= 1'b0;
      b_neg  <= 1'b0;
      dz_r   <= 1'b0;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      rem    <= '0;
      quo    <= '0;
      dvs    <= '0;
      hi_r   <= '0;
      lo_r   <= '0;
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          cnt    <= '0;
          uns_r  <= uns_in;
          a_neg  <= bus.a[DATA_W-1] & ~uns_in;
          b_neg  <= bus.b[DATA_W-1] & ~uns_in;
          dz_r   <= op_is_div(bus.op) && (bus.b == '0);
          mcand  <= uns_in ? {{DATA_W{1'b0}}, bus.a}
                           : {{DATA_W{bus.a[DATA_W-1]}}, bus.a};
          mplier <= bus.b;
          acc    <= '0;
          rem    <= '0;
          quo    <= cond_neg(bus.a, bus.a[DATA_W-1] & ~uns_in);
          dvs    <= cond_neg(bus.b, bus.b[DATA_W-1] & ~uns_in);
        end
        MULT: begin
          cnt    <= cnt + 1'b1;
          acc    <= acc_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          if (last) {hi_r, lo_r} <= acc_next;
        end
        DIV: begin
          cnt <= cnt + 1'b1;
          rem <= rem_step;
          quo <= quo_step;
        end
        // Magnitude results get their signs on the edge that enters DONE
        FIX: begin
          hi_r <= cond_neg(rem, a_neg);
          lo_r <= cond_neg(quo, a_neg ^ b_neg);
        end
        default: ;
      endcase
    end
  end

  assign bus.busy    = (state != IDLE);
  assign bus.done    = (state == DONE);
  assign bus.divZero = (state == DONE) && dz_r;
  assign bus.hi      = hi_r;
  assign bus.lo      = lo_r;

endmodule

// File: tb/tb_mult_div_ctrl.sv
// Scoreboard bench for mult_div_ctrl: directed ops push expected HI/LO/divZero/
// latency; a negedge monitor pops and compares on every done pulse.
module tb_mult_div_ctrl;
  import mult_div_ctrl_pkg::*;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          lat;
    string       name;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   accept_cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  mult_div_ctrl_if bus_if ();

  mult_div_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && bus_if.done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 at cycle %0d expected no done", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk({e.name, "_hi"}, 64'(bus_if.hi), 64'(e.hi));
        chk({e.name, "_lo"}, 64'(bus_if.lo), 64'(e.lo));
        chk({e.name, "_divZero"}, 64'(bus_if.divZero), 64'(e.dz));
        chk({e.name, "_latency"}, 64'(cyc - accept_cyc), 64'(e.lat));
      end
    end
  end

  // Called at a negedge; returns 1 ns after the accepting edge
  task automatic launch(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] hi, input logic [31:0] lo, input logic dz,
                        input int lat, input string name, input bit push);
    exp_t e;
    bus_if.start = 1'b1;
    bus_if.op    = op;
    bus_if.a     = a;
    bus_if.b     = b;
    if (push) begin
      e.hi = hi; e.lo = lo; e.dz = dz; e.lat = lat; e.name = name;
      sb.push_back(e);
    end
    accept_cyc = cyc;
    @(posedge clk);
    #1;
    bus_if.start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (!bus_if.busy) return;
    end
    checks++;
    errors++;
    $display("FAIL %s_timeout: got busy=1 after 60 cycles expected busy=0", name);
  endtask

  task automatic run(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] hi, input logic [31:0] lo, input logic dz,
                     input int lat, input string name);
    launch(op, a, b, hi, lo, dz, lat, name, 1'b1);
    wait_idle(name);
  endtask

  initial begin
    rst          = 1'b1;
    bus_if.start = 1'b0;
    bus_if.op    = 2'b00;
    bus_if.a     = '0;
    bus_if.b     = '0;
    repeat (3) @(negedge clk);
    chk("reset_busy", 64'(bus_if.busy), 64'd0);
    chk("reset_done", 64'(bus_if.done), 64'd0);
    chk("reset_divZero", 64'(bus_if.divZero), 64'd0);
    chk("reset_hi", 64'(bus_if.hi), 64'd0);
    chk("reset_lo", 64'(bus_if.lo), 64'd0);
    rst = 1'b0;

    // accepted on the very first edge after reset release
    run(2'b00, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 33, "mult_7_m3");

    // a start pulse mid-MULT must be ignored
    launch(2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, 1'b0, 33,
           "mult_min_min", 1'b1);
    repeat (4) @(negedge clk);
    bus_if.start = 1'b1;
    bus_if.op    = 2'b01;
    bus_if.a     = 32'd1;
    bus_if.b     = 32'd0;
    @(negedge clk);
    bus_if.start = 1'b0;
    wait_idle("mult_min_min");

    run(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h1, 1'b0, 33, "mult_m1_m1");
    run(2'b01, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 34, "div_100_7");
    run(2'b01, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 34, "div_m7_2");
    run(2'b01, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFF2, 1'b0, 34, "div_m100_7");
    run(2'b01, 32'd100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFF2, 1'b0, 34, "div_100_m7");
    run(2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0, 34, "div_min_m1");
`ifdef MULT_DIV_UNSIGNED_EN
    run(2'b10, 32'hFFFF_FFFF, 32'd2, 32'h1, 32'hFFFF_FFFE, 1'b0, 33, "multu");
    run(2'b11, 32'hFFFF_FFFF, 32'd2, 32'h1, 32'h7FFF_FFFF, 1'b0, 34, "divu");
`else
    run(2'b10, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 33, "multu");
    run(2'b11, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 32'h0, 1'b0, 34, "divu");
`endif
    run(2'b01, 32'h0000_0451, 32'h20, 32'h11, 32'h22, 1'b0, 34, "div_preload");
    run(2'b01, 32'd5, 32'd0, 32'h11, 32'h22, 1'b1, 1, "div_by_zero");

    // reset mid-DIV aborts with no result and no done
    launch(2'b01, 32'd100, 32'd7, 32'h0, 32'h0, 1'b0, 0, "div_abort", 1'b0);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_busy", 64'(bus_if.busy), 64'd0);
    chk("abort_done", 64'(bus_if.done), 64'd0);
    chk("abort_hi", 64'(bus_if.hi), 64'd0);
    chk("abort_lo", 64'(bus_if.lo), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    run(2'b00, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 33, "mult_after_rst");
    repeat (40) @(negedge clk);

    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
